// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN weight path.
// Contents:
//   Q, F_DEFAULT, N_DEFAULT  - weight fraction bits and default array geometry
//   weight_q14_t             - signed Q14 synaptic weight
//   addr_width()             - weight address width for an F x N array
//   wb_req_t                 - one queued weight write (address + data)
//   wbq_state_e              - flush handshake states of the write-back queue
package snn_pkg;

  localparam int Q         = 14;
  localparam int F_DEFAULT = 48;
  localparam int N_DEFAULT = 96;

  typedef logic signed [15:0] weight_q14_t;

  function automatic int addr_width(input int f, input int n);
    return $clog2(f * n);
  endfunction

  // Queue entries are sized for the default array; any F/N override must keep
  // F*N addressable in this many bits.
  localparam int WB_AW = addr_width(F_DEFAULT, N_DEFAULT);

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    weight_q14_t      wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } wbq_state_e;

endpackage

// File: rtl/sync_fifo_mw.sv
// Synchronous FIFO of wb_req_t entries with an extra "merge" write port that
// overwrites the most recently pushed (tail) entry in place.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - append din at the tail
//   merge      - overwrite the tail entry with din (caller guarantees level>0
//                and that the tail is not being popped this edge)
//   pop        - retire the head entry
//   din        - entry to push/merge
//   head       - entry at the read pointer
//   tail_addr  - address field of the tail entry
//   level      - occupancy, 0..DEPTH
module sync_fifo_mw
  import snn_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             merge,
  input  logic             pop,
  input  wb_req_t          din,
  output wb_req_t          head,
  output logic [WB_AW-1:0] tail_addr,
  output logic [PW:0]      level
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   LVL_ONE = (PW + 1)'(1);

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic [PW-1:0] tail_ptr;

  // Pointers wrap naturally at DEPTH (power of two); level tells full from empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    tail_ptr = wr_ptr_q - PTR_ONE;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else if (merge) begin
      mem_d[tail_ptr] = din;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign tail_addr = mem_q[tail_ptr].addr;
  assign level     = level_q;

endmodule

// File: rtl/stdp_wb_queue.sv
// Write-back queue between the STDP update stage and the shared weight SRAM
// write port. Buffers updates, merges back-to-back writes to one address, and
// drains only when inference does not own the port. A flush handshake lets the
// epoch controller wait until every queued update has been committed.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   in_we, in_addr, in_wdata     - write-back stream from STDP (no backpressure)
//   infer_busy                   - inference owns the SRAM port; hold drain
//   flush_req                    - request a full drain
//   flush_done                   - one-cycle pulse when the drain completes
//   mem_we, mem_addr, mem_wdata  - registered SRAM write port
//   level                        - queue occupancy
//   overflow, addr_err, drop_cnt - sticky drop status, cleared by clr_status
module stdp_wb_queue
  import snn_pkg::*;
#(
  parameter int F     = 48,
  parameter int N     = 96,
  parameter int DEPTH = 16,
  localparam int AW   = addr_width(F, N),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_we,
  input  logic [AW-1:0]      in_addr,
  input  logic signed [15:0] in_wdata,
  input  logic               infer_busy,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic signed [15:0] mem_wdata,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output logic               addr_err,
  output logic [15:0]        drop_cnt,
  input  logic               clr_status
);

  localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(F * N);
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);

  wb_req_t          fifo_din, fifo_head;
  logic [WB_AW-1:0] tail_addr;
  logic [LW-1:0]    level_w;
  logic             in_range, valid_push, tail_popped;
  logic             fifo_push, fifo_merge, fifo_pop;
  logic             full_drop, range_drop;

  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic signed [15:0] mem_wdata_q, mem_wdata_d;
  logic               overflow_q, overflow_d;
  logic               addr_err_q, addr_err_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  wbq_state_e state_q;
  logic       flush_done_q;

  sync_fifo_mw #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .merge     (fifo_merge),
    .pop       (fifo_pop),
    .din       (fifo_din),
    .head      (fifo_head),
    .tail_addr (tail_addr),
    .level     (level_w)
  );

  // Push/merge/pop decisions. A merge is refused when the tail is the head
  // being popped, since that entry is leaving the queue this edge. A full
  // queue still takes a new entry if the head pops on the same edge.
  always_comb begin
    fifo_din.addr  = in_addr;
    fifo_din.wdata = in_wdata;
    in_range    = ({1'b0, in_addr} < ADDR_LIMIT);
    valid_push  = in_we && in_range;
    fifo_pop    = (level_w != '0) && !infer_busy;
    tail_popped = fifo_pop && (level_w == LVL_ONE);
    fifo_merge  = valid_push && (level_w != '0) && (tail_addr == in_addr) && !tail_popped;
    fifo_push   = valid_push && !fifo_merge && ((level_w != FULL_LVL) || fifo_pop);
    full_drop   = valid_push && !fifo_merge && (level_w == FULL_LVL) && !fifo_pop;
    range_drop  = in_we && !in_range;
  end

  // SRAM port: strobe for exactly one cycle per pop; address/data hold otherwise.
  always_comb begin
    mem_we_d    = fifo_pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (fifo_pop) begin
      mem_addr_d  = fifo_head.addr;
      mem_wdata_d = fifo_head.wdata;
    end
  end

  // Sticky status; a clear on the same edge as a drop discards that drop.
  always_comb begin
    overflow_d = overflow_q;
    addr_err_d = addr_err_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      addr_err_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (full_drop) begin
        overflow_d = 1'b1;
      end
      if (range_drop) begin
        addr_err_d = 1'b1;
      end
      if ((full_drop || range_drop) && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overflow_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      overflow_q  <= overflow_d;
      addr_err_q  <= addr_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Flush handshake. DRAIN completes only on an edge with an empty queue and
  // no incoming entry, so late pushes extend the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (flush_req) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((level_w == '0) && !fifo_push) begin
            state_q      <= ST_DONE;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign flush_done = flush_done_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign level      = level_w;
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/stdp_wb_queue.md
Name: stdp_wb_queue

Overview:
- Downstream neighbour of the Q14 STDP update stage; consumes its weight write-back stream (we/addr/wdata, one write per cycle max, no backpressure).
- Buffers updates in a small FIFO, merges back-to-back writes to the same address, and drains them into the shared weight-SRAM write port only in cycles where inference does not own the port.
- Provides flush/drain handshake so the epoch controller can guarantee all STDP updates are committed before the next inference pass.

Parameters:
- F, 48, number of presynaptic inputs
- N, 96, number of postsynaptic neurons
- DEPTH, 16, FIFO entries (power of 2, >=2)
- AW, $clog2(F*N) (=13), weight address width (derived localparam, not overridable)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- in_we  in  1  write-back valid from STDP stage
- in_addr  in  AW  weight address (row-major pre*N+post)
- in_wdata  in  16 signed  Q14 weight, already clamped upstream
- infer_busy  in  1  inference owns SRAM port this cycle; no drain
- flush_req  in  1  level/pulse; request full drain
- flush_done  out  1  one-cycle pulse when drain completes
- mem_we  out  1  SRAM write strobe (registered)
- mem_addr  out  AW  SRAM write address (registered)
- mem_wdata  out  16 signed  SRAM write data (registered)
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a write was dropped
- addr_err  out  1  sticky: out-of-range address seen
- drop_cnt  out  16  saturating count of dropped writes
- clr_status  in  1  clears overflow, addr_err, drop_cnt (sync)

Behaviour:
- Reset (async, rst=1): FIFO empty, level=0, state RUN, all outputs 0.
- Push rule at edge: in_we && in_addr < F*N. Address >= F*N -> dropped, addr_err<=1, drop_cnt+1 (sat 16'hFFFF); never enqueued.
- Merge: valid push with level>0 and in_addr == tail entry addr, and tail is not being popped this edge -> overwrite tail wdata; level unchanged. Tail == head being popped -> normal push, no merge.
- Full (level==DEPTH): push accepted only if pop occurs same edge; otherwise dropped, overflow<=1, drop_cnt+1 (sat). Merge into full tail is allowed (no drop).
- Pop at edge: level>0 && !infer_busy. Head registered onto mem_addr/mem_wdata, mem_we=1 for exactly the following cycle; mem_we=0 otherwise (addr/data hold last value).
- Latency: push sampled at edge k -> earliest mem_we high after edge k+1 (2-cycle push-to-write). Throughput 1 write/cycle while infer_busy=0.
- Simultaneous push+pop: level unchanged; empty FIFO with push never pops same edge (no bypass).
- Pointers wrap modulo DEPTH; level distinguishes full/empty.
- FSM: RUN -> DRAIN on flush_req=1. DRAIN -> DONE when level==0 and no push this edge. DONE: flush_done=1 for one cycle, -> RUN. Pushes still accepted in DRAIN (drain extends). flush_req in DRAIN/DONE ignored. flush_req with empty FIFO: DONE next edge, flush_done the cycle after.
- infer_busy always has priority, including in DRAIN.
- clr_status same edge as new drop: clear wins for that edge, drop is lost from counters.
- rst mid-drain: queue contents discarded, no flush_done.

Decomposition:
- Shared package snn_pkg: weight_q14_t (logic signed [15:0]), Q=14, default F/N, wb_req_t struct {addr, wdata}, address-width function.
- One sub-module natural: sync_fifo_mw (DEPTH x wb_req_t, with tail-entry write port for merge, level output). FSM, range check, counters in top.

Test Plan:
- Single write: in_we addr=5 data=16'sh2000, infer_busy=0 -> mem_we high 2 cycles later, mem_addr=5, mem_wdata=16'sh2000, level back to 0.
- Merge: addr=7 data=100 then addr=7 data=200 consecutive cycles, infer_busy=1 -> level=1; release -> one mem write addr=7 data=200.
- Overflow: infer_busy=1, 17 distinct writes -> level=16, overflow=1, drop_cnt=1; release -> 16 writes in push order, then 16 idle cycles.
- Range: addr=4608 -> no enqueue, addr_err=1, drop_cnt=1; clr_status -> both 0.
- Flush: 5 queued, flush_req pulse, infer_busy toggling 1/0 -> exactly 5 mem_we, flush_done single pulse the cycle after level hits 0; flush with empty queue -> flush_done 2 cycles after request.
- Reset mid-drain: 8 queued, DRAIN, rst pulsed -> level=0, mem_we=0, no flush_done, no further writes.
